// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit carry-lookahead slice.
// It processes one nibble per clock, LSB first, between valid/ready request and result ports.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// CALC  | one nibble per clock through the CLA slice, LSB to MSB
// DONE  | out_valid=1, result held until out_ready
module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [IW-1:0]    idx_q;
  logic             c_q, cout_q, ovf_q, in_ready_q, out_valid_q;

  logic [3:0] nib_a, nib_b, g, p, nib_sum_d;
  logic [4:0] cc_d;

  // CLA slice: cc_d[3] is the carry into the nibble MSB, cc_d[4] the carry out.
  always_comb begin
    nib_a     = a_q[{idx_q, 2'b00} +: 4];
    nib_b     = b_q[{idx_q, 2'b00} +: 4];
    g         = nib_a & nib_b;
    p         = nib_a ^ nib_b;
    cc_d[0]   = c_q;
    cc_d[1]   = g[0] | (p[0] & cc_d[0]);
    cc_d[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cc_d[0]);
    cc_d[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cc_d[0]);
    cc_d[4]   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cc_d[0]);
    nib_sum_d = p ^ cc_d[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      idx_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            c_q        <= sub;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          result_q[{idx_q, 2'b00} +: 4] <= nib_sum_d;
          c_q   <= cc_d[4];
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            cout_q      <= cc_d[4];
            ovf_q       <= cc_d[4] ^ cc_d[3];
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (WIDTH=16): an arithmetic reference model
// checked against the DUT every cycle, plus directed cases with literal expectations.
module tb_nibble_serial_addsub;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 0;
  bit rnd    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {overflow, cout, result} from plain two's-complement arithmetic.
  function automatic logic [17:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [16:0]  t;
    logic [W-1:0] r;
    logic         c, v;
    if (!s) begin
      t = {1'b0, x} + {1'b0, y};
      c = t[16];
    end else begin
      t = {1'b0, x} - {1'b0, y};
      c = (x >= y);
    end
    r = t[W-1:0];
    if (!s) v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    else    v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return {v, c, r};
  endfunction

  // Transaction-level model: busy from accept until handshake, result visible NIB cycles after accept.
  logic [17:0] exp_q[$];
  bit m_busy = 0;
  bit m_zero = 1;
  int m_cnt  = 0;
  int n_acc  = 0;
  int n_drop = 0;
  int n_hs   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (m_busy) n_drop++;
      m_busy = 0;
      m_cnt  = 0;
      m_zero = 1;
      exp_q.delete();
    end else if (!m_busy) begin
      if (in_valid) begin
        exp_q.push_back(ref_op(a, b, sub));
        n_acc++;
        m_busy = 1;
        m_cnt  = 0;
        m_zero = 0;
      end
    end else if (m_cnt >= NIB && out_ready) begin
      void'(exp_q.pop_front());
      n_hs++;
      m_busy = 0;
    end else if (m_cnt < NIB) begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_busy && m_cnt >= NIB});
      if (m_busy && m_cnt >= NIB && exp_q.size() > 0) begin
        chk("result", {16'b0, result}, {16'b0, exp_q[0][15:0]});
        chk("cout", {31'b0, cout}, {31'b0, exp_q[0][16]});
        chk("overflow", {31'b0, overflow}, {31'b0, exp_q[0][17]});
      end
      if (m_zero) chk("reset_outs", {14'b0, overflow, cout, result}, 32'h0);
    end
  end

  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          output int acc_cyc);
    bit rdy;
    bit ok;
    ok = 0;
    a = x; b = y; sub = s; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready never seen (t=%0t)", $time);
    end
    acc_cyc = cyc;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_out(output bit seen);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL out_timeout: out_valid never seen (t=%0t)", $time);
    end
  endtask

  task automatic dir_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] er, input logic ec, input logic ev);
    int  acc;
    bit  seen;
    chk({name, "_model"}, {14'b0, ref_op(x, y, s)}, {14'b0, ev, ec, er});
    out_ready = 1'b1;
    drive_op(x, y, s, acc);
    wait_out(seen);
    if (seen) begin
      chk({name, "_latency"}, cyc - acc, NIB);
      chk({name, "_result"}, {16'b0, result}, {16'b0, er});
      chk({name, "_cout"}, {31'b0, cout}, {31'b0, ec});
      chk({name, "_ovf"}, {31'b0, overflow}, {31'b0, ev});
    end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int  acc;
    bit  seen;
    #1 rst = 1'b1;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_outs", {14'b0, overflow, cout, result}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    dir_op("add1", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
    chk("in_ready_after_done", {31'b0, in_ready}, 32'h1);
    dir_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir_op("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    dir_op("borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    dir_op("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    dir_op("subeq", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure with a second request pending during CALC/DONE.
    chk("bp_model", {14'b0, ref_op(16'hC5A7, 16'h7B59, 1'b0)}, {14'b0, 2'b01, 16'h4100});
    out_ready = 1'b0;
    drive_op(16'hC5A7, 16'h7B59, 1'b0, acc);
    a = 16'h0101; b = 16'h0202; sub = 1'b0; in_valid = 1'b1;
    wait_out(seen);
    for (int k = 0; k < 3; k++) begin
      chk("bp_result", {16'b0, result}, 32'h4100);
      chk("bp_cout", {31'b0, cout}, 32'h1);
      chk("bp_busy", {31'b0, in_ready}, 32'h0);
      if (k < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    drive_op(16'h0101, 16'h0202, 1'b0, acc);
    wait_out(seen);
    chk("second_result", {16'b0, result}, 32'h0303);
    @(posedge clk); #1;

    // Reset two cycles into CALC.
    drive_op(16'h1234, 16'h1111, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_outs", {14'b0, overflow, cout, result}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    dir_op("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Random traffic with random consumer stalls.
    rnd = 1;
    for (int i = 0; i < 1000; i++) begin
      drive_op(W'($urandom), W'($urandom), 1'($urandom), acc);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    rnd = 0;
    @(posedge clk); #2 out_ready = 1'b1;
    for (int i = 0; i < 200 && m_busy; i++) @(posedge clk);
    @(negedge clk);
    chk("drained", {31'b0, m_busy}, 32'h0);
    chk("handshakes", n_hs, n_acc - n_drop);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice, processing one nibble per clock from LSB to MSB. It sits behind a valid/ready request port and in front of a valid/ready result port. Datapaths that need wide add/subtract can reuse the existing 4-bit CLA slice instead of building a full-width adder, trading latency for area.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B, 1: A-B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB; on subtract, 1 = no borrow
- overflow  output  1  two's-complement signed overflow

## Operation
- States: IDLE, CALC, DONE. Nibble counter idx, width clog2(WIDTH/4).
- IDLE: in_ready=1. On an edge with in_valid&&in_ready:
  - latch a into A_reg.
  - latch b, or ~b when sub=1, into B_reg.
  - carry register c <= sub.
  - idx <= 0; go to CALC.
- CALC: in_ready=0. Each edge:
  - apply nibble idx of A_reg/B_reg plus c to the 4-bit CLA slice (g=a&b, p=a^b, lookahead carries).
  - write the slice sum into result[4*idx+3:4*idx].
  - c <= slice carry-out; idx <= idx+1.
  - on the edge that processes idx = WIDTH/4-1: cout <= slice carry-out, overflow <= carry into MSB XOR carry out of MSB, then go to DONE.
- DONE: out_valid=1. result, cout and overflow are held stable until an edge with out_ready=1, which moves the block to IDLE.
- in_valid is ignored outside IDLE. A request cannot be accepted on the same edge as the DONE handshake.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- result holds its last value in IDLE and is only guaranteed while out_valid=1.
- Reset (any time, including mid-CALC or in DONE):
  - state <= IDLE; in_ready=1 after reset deasserts.
  - out_valid=0, result=0, cout=0, overflow=0, idx=0, c=0.
  - the in-flight operation is discarded and no result is produced.

## Timing
- in_ready and out_valid are decoded from registered state (Moore). No combinational path from in_valid or out_ready to any output.
- Accept edge E0 → nibbles processed at edges E1..E(WIDTH/4) → out_valid high from E(WIDTH/4) onward. Latency is WIDTH/4 cycles (4 for WIDTH=16).
- With out_ready held high, DONE lasts 1 cycle and in_ready returns the cycle after. Peak throughput is one operation per WIDTH/4+2 cycles.
- Operands may change after E0 without affecting the result.
- Critical path is one 4-bit CLA slice plus mux/register. It is independent of WIDTH.

## Test plan
All cases use WIDTH=16.
- Add, latency and handshake: a=0x0001, b=0x0002, sub=0, out_ready=1 → result=0x0003, cout=0, overflow=0. out_valid rises exactly 4 edges after accept, stays high 1 cycle, then in_ready=1.
- Carry ripple across all nibbles: 0xFFFF+0x0001 → 0x0000, cout=1, overflow=0. Then 0x7FFF+0x0001 → 0x8000, cout=0, overflow=1.
- Subtract and borrow: 0x0005-0x0007 → 0xFFFE, cout=0, overflow=0. Then 0x8000-0x0001 → 0x7FFF, cout=1, overflow=1. Then 0x1234-0x1234 → 0x0000, cout=1.
- Backpressure and busy: 0xC5A7+0x7B59 with out_ready low for 3 cycles in DONE → result=0x4100 and cout=1 stay stable throughout. A second request with in_valid high during CALC/DONE is not accepted until in_ready=1.
- Reset mid-operation: assert rst two cycles into CALC → out_valid=0, result=0, cout=0, overflow=0, in_ready=1 after release. A following request 0x0003+0x0004 returns 0x0007 with normal 4-cycle latency.
- Random: 1000 random a/b/sub with random out_ready stalls → result, cout and overflow match a reference model computing (a ± b) mod 2^16. Exactly one out_valid handshake per accepted request, in order.
